// File: rtl/mux_pkg.sv
// Shared definitions for the scanning channel multiplexer.
// Mode encoding and the index-width helper used to size channel and dwell counters.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Ceiling log2, never less than 1, so a counter for a single state still has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer: dwell counter and scan index, plus a flag that marks the
// first output cycle after the index wrapped from N-1 back to 0.
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 4,
    localparam int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    output logic [SELW-1:0] scan_idx,
    output logic            wrap_nxt
);

    localparam int DWW = clog2(DWELL);

    logic [SELW-1:0] idx_q, idx_d;
    logic [DWW-1:0]  dwell_q, dwell_d;
    logic            wrapped_q, wrapped_d;

    always_comb begin
        idx_d     = idx_q;
        dwell_d   = dwell_q;
        wrapped_d = wrapped_q;
        if (en) begin
            wrapped_d = 1'b0;
            if (mode_e'(mode) == MODE_MANUAL) begin
                idx_d   = '0;
                dwell_d = '0;
            end else if (dwell_q == DWW'(DWELL - 1)) begin
                dwell_d = '0;
                // Wrap at N-1, not at the top of the index range.
                if (idx_q == SELW'(N - 1)) begin
                    idx_d     = '0;
                    wrapped_d = 1'b1;
                end else begin
                    idx_d = idx_q + SELW'(1);
                end
            end else begin
                dwell_d = dwell_q + DWW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            dwell_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign scan_idx = idx_q;
    assign wrap_nxt = wrapped_q && (mode_e'(mode) == MODE_SCAN);

endmodule

// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer with manual channel select or automatic scan.
// Out-of-range manual indices are reported on ch with y_valid low and y zeroed.
module mux_n_1_scan
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 1,
    parameter int DWELL = 4,
    localparam int SELW = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] din,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    input  logic               en,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid,
    output logic [SELW-1:0]    ch,
    output logic               wrap
);

    logic [SELW-1:0]  scan_idx;
    logic             wrap_nxt;
    logic [SELW-1:0]  eff_idx;
    logic             in_range;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             wrap_q, wrap_d;

    mux_scan_ctrl #(
        .N     (N),
        .DWELL (DWELL)
    ) u_scan_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .scan_idx (scan_idx),
        .wrap_nxt (wrap_nxt)
    );

    always_comb begin
        eff_idx  = (mode_e'(mode) == MODE_SCAN) ? scan_idx : sel;
        in_range = ({1'b0, eff_idx} < (SELW + 1)'(N));
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (eff_idx == SELW'(k)) begin
                sel_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        ch_d    = ch_q;
        wrap_d  = 1'b0;
        if (en) begin
            y_d     = in_range ? sel_data : '0;
            valid_d = in_range;
            ch_d    = eff_idx;
            wrap_d  = wrap_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y       = y_q;
    assign y_valid = valid_q;
    assign ch      = ch_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Bench for mux_n_1_scan: a 4-channel/DWELL=3 instance and a 3-channel/DWELL=1 instance.
module tb_mux_n_1_scan;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
        logic [1:0] ch;
        logic       w;
    } obs_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] a_din;
    logic [1:0]  a_sel;
    logic        a_mode, a_en;
    logic [7:0]  a_y;
    logic        a_v;
    logic [1:0]  a_ch;
    logic        a_wrap;

    logic [23:0] b_din;
    logic [1:0]  b_sel;
    logic        b_mode, b_en;
    logic [7:0]  b_y;
    logic        b_v;
    logic [1:0]  b_ch;
    logic        b_wrap;

    mux_n_1_scan #(.N(4), .WIDTH(8), .DWELL(3)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (a_din),
        .sel     (a_sel),
        .mode    (a_mode),
        .en      (a_en),
        .y       (a_y),
        .y_valid (a_v),
        .ch      (a_ch),
        .wrap    (a_wrap)
    );

    mux_n_1_scan #(.N(3), .WIDTH(8), .DWELL(1)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (b_din),
        .sel     (b_sel),
        .mode    (b_mode),
        .en      (b_en),
        .y       (b_y),
        .y_valid (b_v),
        .ch      (b_ch),
        .wrap    (b_wrap)
    );

    // scoreboard
    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    obs_t last_a;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic [7:0] y, input logic v, input logic [1:0] ch, input logic w);
        obs_t o;
        o.y  = y;
        o.v  = v;
        o.ch = ch;
        o.w  = w;
        return o;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] bus, input int k);
        return bus[k*8 +: 8];
    endfunction

    // driver tasks
    task automatic step(input bit use_b, input obs_t exp, input string tag);
        obs_t got;
        obs_t e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = use_b ? {b_y, b_v, b_ch, b_wrap} : {a_y, a_v, a_ch, a_wrap};
        e = exp_q.pop_front();
        check({tag, ".y"},     16'(got.y),  16'(e.y));
        check({tag, ".valid"}, 16'(got.v),  16'(e.v));
        check({tag, ".ch"},    16'(got.ch), 16'(e.ch));
        check({tag, ".wrap"},  16'(got.w),  16'(e.w));
        if (!use_b) last_a = e;
    endtask

    task automatic scan_a(input logic [1:0] exp_ch, input logic exp_w, input string tag);
        a_din = $urandom;
        a_sel = 2'($urandom_range(0, 3));
        step(1'b0, mk(lane(a_din, int'(exp_ch)), 1'b1, exp_ch, exp_w), tag);
    endtask

    task automatic scan_b(input logic [1:0] exp_ch, input logic exp_w, input string tag);
        b_din = 24'($urandom);
        b_sel = 2'($urandom_range(0, 3));
        step(1'b1, mk(lane({8'h00, b_din}, int'(exp_ch)), 1'b1, exp_ch, exp_w), tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        a_din  = '0; a_sel = '0; a_mode = 1'b0; a_en = 1'b1;
        b_din  = '0; b_sel = '0; b_mode = 1'b0; b_en = 1'b1;

        // reset with din toggling
        for (int i = 0; i < 2; i++) begin
            a_din = (i == 0) ? 32'hFFFF_FFFF : 32'h5A5A_A5A5;
            step(1'b0, mk(8'h00, 1'b0, 2'd0, 1'b0), "reset");
        end

        // manual select of each channel
        rst_n = 1'b1;
        a_din = 32'hD4C3_B2A1;
        for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k);
            step(1'b0, mk(lane(a_din, k), 1'b1, 2'(k), 1'b0), "manual");
        end

        // three-channel instance: out-of-range index, then DWELL=1 scan
        b_din = 24'h33_2211;
        b_sel = 2'd3;
        step(1'b1, mk(8'h00, 1'b0, 2'd3, 1'b0), "oor");
        b_sel = 2'd2;
        step(1'b1, mk(8'h33, 1'b1, 2'd2, 1'b0), "b_manual");
        b_sel = 2'd3;
        step(1'b1, mk(8'h00, 1'b0, 2'd3, 1'b0), "oor2");
        b_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            scan_b(2'(i % 3), (i == 3) || (i == 6), "b_scan");
        end
        b_en = 1'b0;

        // full scan cycle with wrap
        a_mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            scan_a((i < 12) ? 2'(i / 3) : 2'd0, (i == 12), "scan");
        end
        scan_a(2'd0, 1'b0, "scan");

        // freeze mid-dwell
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_din = $urandom;
            step(1'b0, mk(last_a.y, 1'b1, 2'd0, 1'b0), "freeze");
        end
        a_en = 1'b1;
        scan_a(2'd0, 1'b0, "resume");
        scan_a(2'd1, 1'b0, "resume");
        scan_a(2'd1, 1'b0, "resume");

        // reset mid-scan aborts, next scan starts at channel 0 with full dwell
        rst_n = 1'b0;
        a_din = $urandom;
        step(1'b0, mk(8'h00, 1'b0, 2'd0, 1'b0), "abort");
        rst_n = 1'b1;
        scan_a(2'd0, 1'b0, "restart");
        scan_a(2'd0, 1'b0, "restart");
        scan_a(2'd0, 1'b0, "restart");
        scan_a(2'd1, 1'b0, "restart");
        scan_a(2'd1, 1'b0, "restart");
        scan_a(2'd1, 1'b0, "restart");
        scan_a(2'd2, 1'b0, "restart");

        // scan -> manual -> scan
        a_mode = 1'b0;
        a_sel  = 2'd1;
        a_din  = $urandom;
        step(1'b0, mk(lane(a_din, 1), 1'b1, 2'd1, 1'b0), "to_manual");
        a_mode = 1'b1;
        scan_a(2'd0, 1'b0, "to_scan");
        scan_a(2'd0, 1'b0, "to_scan");
        scan_a(2'd0, 1'b0, "to_scan");
        scan_a(2'd1, 1'b0, "to_scan");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
